fft_frame_buffer: RTL
=====================

Name: fft_frame_buffer

Overview:
- Downstream neighbour of the codec audio core. Takes the mono 24-bit sample and LR clock it produces, and moves them into the CLOCK_50 domain.
- Accumulates FRAME_LEN consecutive samples in a ping-pong buffer. Each complete frame is streamed to the FFT core over a valid/ready streaming interface with start-of-packet and end-of-packet marks.
- Decouples the 48 kHz sample arrival from FFT back-pressure and flags dropped frames.

Parameters:
- DATA_W, 24, sample width; matches the audio core output.
- FRAME_LEN, 256, samples per FFT frame; must be a power of two, range 4..4096.
- ADDR_W, $clog2(FRAME_LEN), sample index width; derived, not overridden.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- LRC_IN  in  1  LR clock from the audio core; asynchronous to CLOCK_50.
- DATA_IN  in  DATA_W  mono sample from the audio core; changes only on LRC_IN rising edge.
- src_ready  in  1  FFT sink ready.
- src_valid  out  1  output beat valid.
- src_data  out  DATA_W  output sample.
- src_sop  out  1  first beat of a frame.
- src_eop  out  1  last beat of a frame.
- overrun  out  1  one-cycle pulse when a frame is dropped.
- frame_cnt  out  16  count of frames fully streamed; wraps at 65535.

Behaviour:
- One clock (CLOCK_50). Reset is synchronous and active-high; all state is cleared on the CLOCK_50 edge while reset=1.
- Reset values:
  - src_valid, src_sop, src_eop, overrun = 0.
  - src_data = 0, frame_cnt = 0.
  - Write index = 0, fill bank = 0, read FSM = IDLE, LRC sync flops = 0.
  - Buffer contents are not reset.
- Input capture:
  - LRC_IN passes through a 3-flop chain. A rising edge is detected between flops 2 and 3 (s2 & !s3).
  - On that edge, DATA_IN is sampled directly. It has been stable for at least 2 CLOCK_50 cycles, and the LRC period of about 20.8 us gives a wide margin. No synchronizer is needed on the data bus.
  - The sample is written to fill_bank[wr_idx], then wr_idx increments.
  - The edge fires exactly once per LRC_IN rising edge. An LRC_IN glitch shorter than one CLOCK_50 cycle may be missed, and that is acceptable.
- Bank swap, evaluated when the write that fills index FRAME_LEN-1 occurs:
  - If the read FSM is IDLE, or finishes its final beat in that same cycle: fill bank toggles, the completed bank becomes the read bank, and wr_idx wraps to 0.
  - Otherwise (still STREAM): the frame is dropped. overrun pulses for 1 cycle, the fill bank is not toggled, and wr_idx wraps to 0, so the next frame overwrites the same bank.
- Read FSM:
  - IDLE -> PRIME on swap. PRIME issues the read of index 0.
  - PRIME -> STREAM after 1 cycle. src_valid=1, src_sop=1, src_data = sample 0.
  - STREAM: a beat transfers when src_valid & src_ready. On transfer, the next sample is presented in the very next cycle; full throughput of 1 beat per cycle is required (prefetch or skid register as needed).
  - When src_ready=0, src_valid/src_data/src_sop/src_eop hold unchanged.
  - src_sop is high only on beat 0; src_eop is high only on beat FRAME_LEN-1.
  - When the eop beat transfers: src_valid falls next cycle, frame_cnt increments, FSM -> IDLE. A swap in that same cycle goes directly to PRIME.
- Latency: from the swap cycle, src_valid rises 2 cycles later.
- Reset mid-frame: a partial input frame and any in-flight output are abandoned. No eop is emitted and frame_cnt is not incremented.
- Samples are passed unmodified; there is no windowing or scaling.

Decomposition:
- Shared package fft_pkg:
  - DATA_W and FRAME_LEN defaults.
  - Read-FSM state encoding: IDLE = 2'd0, PRIME = 2'd1, STREAM = 2'd2.
- Sub-module lrc_edge_sync:
  - 3-flop synchronizer plus rising-edge pulse on CLOCK_50, with synchronous reset.
  - Reusable for any other codec-domain strobe.
- Buffer RAM is inferred inside fft_frame_buffer as a single 2*FRAME_LEN x DATA_W array: simple dual-port, 1-cycle read latency. Address = {bank, idx}.

Test Plan:
- Basic frame, FRAME_LEN=8, src_ready=1: 8 LRC edges with DATA_IN = 1..8 -> 8 beats 1..8; sop on beat 1, eop on beat 8; src_valid rises 2 cycles after the 8th capture; frame_cnt=1.
- Back-pressure: toggle src_ready 1,0,0,1 pattern through a frame -> each beat held while ready=0; order 1..8 intact; no duplicates or drops.
- Overrun: src_ready=0 throughout while 16 samples arrive -> frame 1 (1..8) still presented; overrun pulses once on the 16th capture; after ready=1, output is 1..8, and samples 17..24 form the next frame.
- Simultaneous eop and swap: time src_ready so the eop beat transfers in the same cycle as the 8th write of the next frame -> no overrun; next frame streams with sop 2 cycles later.
- Reset mid-stream: reset for 1 cycle after beat 3 -> src_valid=0 next cycle, frame_cnt=0; the next 8 samples produce a clean sop-to-eop frame.
- LRC sync: LRC_IN high for 1000 CLOCK_50 cycles, asynchronous phase -> exactly 1 capture per rising edge; DATA_IN changed 1 cycle after the LRC_IN rise -> the new value is captured.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame buffer: default sizes and read-FSM encoding.
package fft_pkg;

    localparam int DATA_W_DEF    = 24;
    localparam int FRAME_LEN_DEF = 256;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

endpackage

// File: rtl/lrc_edge_sync.sv
// Three-flop synchronizer for a codec-domain strobe with a one-cycle rising-edge pulse.
module lrc_edge_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    // Shift the asynchronous strobe through three flops; s1 absorbs metastability.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: captures codec samples on LRC edges and streams whole
// frames to the FFT core over valid/ready with sop/eop marks.
//
// Read FSM states:
//   state     | meaning
//   RD_IDLE   | no frame to send; waiting for a bank swap
//   RD_PRIME  | RAM read of index 0 in flight
//   RD_STREAM | src_valid high; one beat per src_valid & src_ready
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              LRC_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              src_ready,
    output logic              src_valid,
    output logic [DATA_W-1:0] src_data,
    output logic              src_sop,
    output logic              src_eop,
    output logic              overrun,
    output logic [15:0]       frame_cnt
);

    localparam int                ADDR_W   = $clog2(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    logic                cap;
    logic [DATA_W-1:0]   mem [2*FRAME_LEN];
    logic [DATA_W-1:0]   rd_q;
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]   out_idx;
    logic [ADDR_W-1:0]   out_idx_nxt;
    logic [ADDR_W:0]     rd_addr;
    logic                fill_bank;
    logic                rd_bank;
    rd_state_t           state;
    rd_state_t           state_nxt;
    logic                xfer;
    logic                eop_xfer;
    logic                last_wr;
    logic                swap;

    lrc_edge_sync u_lrc_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .async_in (LRC_IN),
        .rise     (cap)
    );

    // Beat flags decode from the presented index; src_data is forced to zero
    // while idle so it reads as 0 out of reset without resetting the RAM register.
    assign src_valid = (state == RD_STREAM);
    assign src_sop   = src_valid && (out_idx == '0);
    assign src_eop   = src_valid && (out_idx == LAST_IDX);
    assign src_data  = src_valid ? rd_q : '0;

    assign xfer     = src_valid & src_ready;
    assign eop_xfer = xfer & src_eop;
    assign last_wr  = cap && (wr_idx == LAST_IDX);
    // A completed frame is accepted if the reader is idle or leaves STREAM this very cycle.
    assign swap     = last_wr && ((state == RD_IDLE) || eop_xfer);

    // The RAM always reads the index to be presented next cycle, so stalls
    // simply re-read the same word and a transfer prefetches the following one.
    assign rd_addr = {rd_bank, out_idx_nxt};

    // Write side: index advance, bank ownership and drop detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_idx    <= '0;
            fill_bank <= 1'b0;
            rd_bank   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= last_wr & ~swap;
            if (cap) begin
                wr_idx <= wr_idx + IDX_ONE;
            end
            if (swap) begin
                fill_bank <= ~fill_bank;
                rd_bank   <= fill_bank;
            end
        end
    end

    // Simple dual-port buffer, one-cycle registered read; contents are never reset.
    always_ff @(posedge CLOCK_50) begin
        if (cap) begin
            mem[{fill_bank, wr_idx}] <= DATA_IN;
        end
        rd_q <= mem[rd_addr];
    end

    // Read FSM state register, beat index and completed-frame counter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= RD_IDLE;
            out_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            state   <= state_nxt;
            out_idx <= out_idx_nxt;
            if (eop_xfer) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Read FSM next-state and next beat index.
    always_comb begin
        state_nxt   = state;
        out_idx_nxt = out_idx;
        case (state)
            RD_IDLE: begin
                out_idx_nxt = '0;
                if (swap) begin
                    state_nxt = RD_PRIME;
                end
            end
            RD_PRIME: begin
                out_idx_nxt = '0;
                state_nxt   = RD_STREAM;
            end
            RD_STREAM: begin
                if (xfer) begin
                    out_idx_nxt = out_idx + IDX_ONE;
                    if (src_eop) begin
                        state_nxt = swap ? RD_PRIME : RD_IDLE;
                    end
                end
            end
            default: begin
                state_nxt   = RD_IDLE;
                out_idx_nxt = '0;
            end
        endcase
    end

endmodule
